// File: rtl/tic_tac_toe_game_ctrl.sv
// Tic-tac-toe game controller: takes moves over valid/ready, alternates turns, and latches win/draw.
// Optional per-turn idle timeout (forfeit) is enabled by defining TIC_TAC_TOE_MOVE_TIMEOUT_EN.
module tic_tac_toe_game_ctrl #(
  parameter logic        FIRST_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_accepted,
  output logic       move_rejected,
  output logic [8:0] X,
  output logic [8:0] O,
  output logic       turn_O,
  output logic       game_over,
  output logic       winner_X,
  output logic       winner_O,
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic       draw
);

  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d, o_q, o_d;
  logic       turn_q, turn_d;
  logic       acc_q, acc_d, rej_q, rej_d;
  logic       over_q, over_d, wx_q, wx_d, wo_q, wo_d, draw_q, draw_d;
  logic [8:0] cell_mask;
  logic       legal;

`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
`endif

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Out-of-range cells decode to an empty mask, which makes them illegal.
  always_comb begin
    cell_mask = '0;
    for (int i = 0; i < 9; i++) begin
      if (move_cell == 4'(i)) cell_mask[i] = 1'b1;
    end
    legal = (cell_mask != 9'd0) && ((cell_mask & (x_q | o_q)) == 9'd0);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    o_d     = o_q;
    turn_d  = turn_q;
    acc_d   = 1'b0;
    rej_d   = 1'b0;
    over_d  = over_q;
    wx_d    = wx_q;
    wo_d    = wo_q;
    draw_d  = draw_q;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    if (new_game) begin
      state_d = PLAY;
      x_d     = '0;
      o_d     = '0;
      turn_d  = FIRST_PLAYER;
      over_d  = 1'b0;
      wx_d    = 1'b0;
      wo_d    = 1'b0;
      draw_d  = 1'b0;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (move_valid) begin
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (legal) begin
              if (turn_q) o_d = o_q | cell_mask;
              else        x_d = x_q | cell_mask;
              acc_d   = 1'b1;
              state_d = CHECK;
            end else begin
              rej_d = 1'b1;
            end
          end
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            // The player to move forfeits; the opponent is credited with the win.
            to_d    = 1'b1;
            over_d  = 1'b1;
            wx_d    = turn_q;
            wo_d    = ~turn_q;
            state_d = OVER;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
        CHECK: begin
          if (has_line(x_q)) begin
            wx_d    = 1'b1;
            over_d  = 1'b1;
            state_d = OVER;
          end else if (has_line(o_q)) begin
            wo_d    = 1'b1;
            over_d  = 1'b1;
            state_d = OVER;
          end else if ((x_q | o_q) == 9'h1FF) begin
            draw_d  = 1'b1;
            over_d  = 1'b1;
            state_d = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        OVER:    ;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      x_q     <= '0;
      o_q     <= '0;
      turn_q  <= FIRST_PLAYER;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      over_q  <= 1'b0;
      wx_q    <= 1'b0;
      wo_q    <= 1'b0;
      draw_q  <= 1'b0;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      o_q     <= o_d;
      turn_q  <= turn_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
      over_q  <= over_d;
      wx_q    <= wx_d;
      wo_q    <= wo_d;
      draw_q  <= draw_d;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign move_ready    = (state_q == PLAY);
  assign move_accepted = acc_q;
  assign move_rejected = rej_q;
  assign X             = x_q;
  assign O             = o_q;
  assign turn_O        = turn_q;
  assign game_over     = over_q;
  assign winner_X      = wx_q;
  assign winner_O      = wo_q;
  assign draw          = draw_q;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
  assign timeout       = to_q;
`endif

endmodule

// File: tb/tb_tic_tac_toe_game_ctrl.sv
// Bench for tic_tac_toe_game_ctrl: directed scenarios plus random games against a board-level model.
module tb_tic_tac_toe_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_cell = 4'd0;
  logic       move_ready, move_accepted, move_rejected;
  logic [8:0] X, O;
  logic       turn_O, game_over, winner_X, winner_O, draw;
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
  logic       timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: board cells hold 0 = empty, 1 = X, 2 = O; turn is 0 for X, 1 for O.
  int board[9];
  int m_turn;
  bit m_over, m_wx, m_wo, m_draw;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  tic_tac_toe_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .move_ready(move_ready), .move_accepted(move_accepted),
    .move_rejected(move_rejected), .X(X), .O(O), .turn_O(turn_O),
    .game_over(game_over), .winner_X(winner_X), .winner_O(winner_O),
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
    .timeout(timeout),
`endif
    .draw(draw)
  );

  always #5 clk = ~clk;

  function automatic bit won(int who);
    for (int l = 0; l < 8; l++)
      if (board[lines[l][0]] == who && board[lines[l][1]] == who && board[lines[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] vec(int who);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) if (board[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit full();
    for (int i = 0; i < 9; i++) if (board[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) board[i] = 0;
    m_turn = 0; m_over = 0; m_wx = 0; m_wo = 0; m_draw = 0;
  endtask

  task automatic apply_move(input int c);
    bit legal;
    legal = (c <= 8) && (board[c] == 0);
    @(negedge clk);
    move_valid = 1'b1; move_cell = 4'(c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    n_checks++;
    if (move_accepted !== legal || move_rejected !== !legal) begin
      n_fail++;
      $display("FAIL pulse cell=%0d acc=%b rej=%b expected acc=%b", c, move_accepted, move_rejected, legal);
    end
    if (legal) board[c] = m_turn + 1;
    n_checks++;
    if (X !== vec(1) || O !== vec(2) || turn_O !== m_turn[0]) begin
      n_fail++;
      $display("FAIL board cell=%0d X=%h O=%h turn=%b expected X=%h O=%h turn=%0d", c, X, O, turn_O, vec(1), vec(2), m_turn);
    end
    n_checks++;
    if (move_ready !== !legal) begin
      n_fail++;
      $display("FAIL ready_after_move cell=%0d got %b expected %b", c, move_ready, !legal);
    end
    if (legal) begin
      @(posedge clk); #1;
      if (won(1)) m_wx = 1;
      else if (won(2)) m_wo = 1;
      else if (full()) m_draw = 1;
      else m_turn ^= 1;
      m_over = m_wx | m_wo | m_draw;
      n_checks++;
      if (winner_X !== m_wx || winner_O !== m_wo || draw !== m_draw || game_over !== m_over ||
          turn_O !== m_turn[0] || move_ready !== !m_over || move_accepted !== 1'b0) begin
        n_fail++;
        $display("FAIL result cell=%0d wx=%b wo=%b dr=%b go=%b turn=%b rdy=%b acc=%b expected %b %b %b %b %0d %b 0",
                 c, winner_X, winner_O, draw, game_over, turn_O, move_ready, move_accepted,
                 m_wx, m_wo, m_draw, m_over, m_turn, !m_over);
      end
    end
  endtask

  task automatic start_game(input bit with_move);
    @(negedge clk);
    new_game = 1'b1; move_valid = with_move; move_cell = 4'($urandom_range(0, 8));
    @(posedge clk); #1;
    new_game = 1'b0; move_valid = 1'b0;
    model_clear();
    n_checks++;
    if (X !== 9'd0 || O !== 9'd0 || turn_O !== 1'b0 || game_over !== 1'b0 || winner_X !== 1'b0 ||
        winner_O !== 1'b0 || draw !== 1'b0 || move_accepted !== 1'b0 || move_rejected !== 1'b0 ||
        move_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL new_game X=%h O=%h turn=%b go=%b wx=%b wo=%b dr=%b acc=%b rej=%b rdy=%b expected all clear, ready=1",
               X, O, turn_O, game_over, winner_X, winner_O, draw, move_accepted, move_rejected, move_ready);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if (X !== 9'd0 || O !== 9'd0 || turn_O !== 1'b0 || move_ready !== 1'b1 || move_accepted !== 1'b0 ||
        move_rejected !== 1'b0 || game_over !== 1'b0 || winner_X !== 1'b0 || winner_O !== 1'b0 || draw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset X=%h O=%h turn=%b rdy=%b acc=%b rej=%b go=%b expected 0 0 0 1 0 0 0",
               X, O, turn_O, move_ready, move_accepted, move_rejected, game_over);
    end
    @(negedge clk); rst = 1'b0;
    model_clear();
  endtask

  task automatic test_x_wins();
    start_game(1'b0);
    apply_move(0); apply_move(1); apply_move(4); apply_move(2); apply_move(8);
    n_checks++;
    if (X !== 9'h111 || O !== 9'h006 || winner_X !== 1'b1 || game_over !== 1'b1 || move_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL x_wins X=%h O=%h wx=%b go=%b rdy=%b expected 111 006 1 1 0", X, O, winner_X, game_over, move_ready);
    end
  endtask

  task automatic test_replay_and_bad_cell();
    start_game(1'b0);
    apply_move(4); apply_move(4);
    n_checks++;
    if (turn_O !== 1'b1 || O !== 9'd0) begin
      n_fail++;
      $display("FAIL replay turn=%b O=%h expected 1 000", turn_O, O);
    end
    apply_move(5); apply_move(9); apply_move(15);
    n_checks++;
    if (X !== 9'h010 || O !== 9'h020) begin
      n_fail++;
      $display("FAIL bad_cell X=%h O=%h expected 010 020", X, O);
    end
  endtask

  task automatic test_draw_and_over();
    start_game(1'b0);
    apply_move(0); apply_move(1); apply_move(2); apply_move(4); apply_move(3);
    apply_move(5); apply_move(7); apply_move(6); apply_move(8);
    n_checks++;
    if (X !== 9'h18D || O !== 9'h072 || draw !== 1'b1 || winner_X !== 1'b0 || winner_O !== 1'b0) begin
      n_fail++;
      $display("FAIL draw X=%h O=%h dr=%b wx=%b wo=%b expected 18D 072 1 0 0", X, O, draw, winner_X, winner_O);
    end
    // A move presented while the game is over produces no pulse and no change.
    @(negedge clk); move_valid = 1'b1; move_cell = 4'd3;
    @(posedge clk); #1; move_valid = 1'b0;
    n_checks++;
    if (move_accepted !== 1'b0 || move_rejected !== 1'b0 || X !== 9'h18D || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL over_hold acc=%b rej=%b X=%h go=%b expected 0 0 18D 1", move_accepted, move_rejected, X, game_over);
    end
    start_game(1'b1);
    apply_move(2); apply_move(6);
    start_game(1'b1);
  endtask

  task automatic test_rst_mid_game();
    start_game(1'b0);
    apply_move(3); apply_move(7);
    @(negedge clk); #1 rst = 1'b1; #1;
    n_checks++;
    if (X !== 9'd0 || O !== 9'd0 || turn_O !== 1'b0 || move_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async X=%h O=%h turn=%b rdy=%b expected 0 0 0 1", X, O, turn_O, move_ready);
    end
    @(negedge clk); rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 25; g++) begin
      int guard = 0;
      start_game($urandom_range(0, 1) == 1);
      while (!m_over && guard < 60) begin
        int c;
        c = $urandom_range(0, 11);
        if (c <= 8 && $urandom_range(0, 3) != 0)
          for (int k = 0; k < 9; k++) if (board[(c + k) % 9] == 0) begin c = (c + k) % 9; break; end
        apply_move(c);
        guard++;
      end
      n_checks++;
      if (!m_over) begin
        n_fail++;
        $display("FAIL random_game_end game=%0d go=%b expected 1 within 60 moves", g, game_over);
      end
    end
  endtask

`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
  task automatic test_timeout();
    start_game(1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (timeout !== (i == 10)) begin
        n_fail++;
        $display("FAIL timeout_idle cycle=%0d got %b expected %b", i, timeout, (i == 10));
      end
    end
    n_checks++;
    if (winner_O !== 1'b1 || winner_X !== 1'b0 || game_over !== 1'b1 || X !== 9'd0) begin
      n_fail++;
      $display("FAIL timeout_result wo=%b wx=%b go=%b X=%h expected 1 0 1 000", winner_O, winner_X, game_over, X);
    end
    start_game(1'b0);
    repeat (9) begin
      @(posedge clk); #1;
      n_checks++;
      if (timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early got %b expected 0", timeout);
      end
    end
    apply_move(4);
    n_checks++;
    if (timeout !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_saved to=%b go=%b expected 0 0", timeout, game_over);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_x_wins();
    test_replay_and_bad_cell();
    test_draw_and_over();
    test_rst_mid_game();
    test_random_games();
`ifdef TIC_TAC_TOE_MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
